dmem_lane_serializer: RTL and testbench



---
 rtl/dmem_lane_serializer.sv | 154 +++++++++++++++
 tb/tb_dmem_lane_serializer.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_lane_serializer.sv
// rtl/dmem_lane_serializer.sv - issues one multi-lane dcache request lane by lane on a TL-UL A/D port
// and gathers the per-lane replies into a single dcache response.
module dmem_lane_serializer #(
  parameter int NUM_LANES = 4,
  parameter int TAG_WIDTH = 8,
  parameter int SRC_WIDTH = TAG_WIDTH + $clog2(NUM_LANES)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [NUM_LANES-1:0]     req_mask,
  input  logic [NUM_LANES-1:0]     req_rw,
  input  logic [4*NUM_LANES-1:0]   req_byteen,
  input  logic [30*NUM_LANES-1:0]  req_addr,
  input  logic [32*NUM_LANES-1:0]  req_data,
  input  logic [TAG_WIDTH-1:0]     req_tag,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [NUM_LANES-1:0]     rsp_tmask,
  output logic [32*NUM_LANES-1:0]  rsp_data,
  output logic [TAG_WIDTH-1:0]     rsp_tag,
  output logic                     mem_a_valid,
  input  logic                     mem_a_ready,
  output logic [2:0]               mem_a_opcode,
  output logic [3:0]               mem_a_size,
  output logic [SRC_WIDTH-1:0]     mem_a_source,
  output logic [31:0]              mem_a_address,
  output logic [3:0]               mem_a_mask,
  output logic [31:0]              mem_a_data,
  input  logic                     mem_d_valid,
  output logic                     mem_d_ready,
  input  logic [2:0]               mem_d_opcode,
  input  logic [SRC_WIDTH-1:0]     mem_d_source,
  input  logic [31:0]              mem_d_data,
  output logic                     busy,
  output logic                     err
);
  localparam int LB = $clog2(NUM_LANES);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t                 state;
  logic [NUM_LANES-1:0]   issue_pend;
  logic [NUM_LANES-1:0]   rsp_pend;
  logic [NUM_LANES-1:0]   rd_mask;
  logic [NUM_LANES-1:0]   rw_q;
  logic [TAG_WIDTH-1:0]   tag_q;
  logic [3:0]             byteen_q [NUM_LANES];
  logic [29:0]            addr_q   [NUM_LANES];
  logic [31:0]            wdata_q  [NUM_LANES];
  logic [31:0]            data_buf [NUM_LANES];
  logic                   err_q;

  logic [LB-1:0]          a_lane;
  logic [LB-1:0]          d_lane;
  logic [TAG_WIDTH-1:0]   d_tag;
  logic                   a_fire;
  logic                   d_fire;
  logic                   d_ok;
  logic [NUM_LANES-1:0]   issue_nx;
  logic [NUM_LANES-1:0]   rsp_nx;

  // Lowest pending lane wins, so lane order is fixed for the whole request.
  always_comb begin
    a_lane = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--)
      if (issue_pend[i]) a_lane = LB'(i);
  end

  assign mem_a_valid   = (state == ISSUE);
  assign mem_a_opcode  = !rw_q[a_lane] ? 3'd4 : (byteen_q[a_lane] == 4'hF) ? 3'd0 : 3'd1;
  assign mem_a_size    = 4'd2;
  assign mem_a_source  = {tag_q, a_lane};
  assign mem_a_address = {addr_q[a_lane], 2'b00};
  assign mem_a_mask    = byteen_q[a_lane];
  assign mem_a_data    = wdata_q[a_lane];

  assign req_ready   = (state == IDLE) && !reset;
  assign mem_d_ready = !reset;
  assign busy        = (state != IDLE);
  assign err         = err_q;

  assign rsp_valid = (state == RESP);
  assign rsp_tmask = rd_mask;
  assign rsp_tag   = tag_q;
  always_comb begin
    rsp_data = '0;
    for (int i = 0; i < NUM_LANES; i++)
      rsp_data[32*i +: 32] = rd_mask[i] ? data_buf[i] : 32'h0;
  end

  assign d_lane = mem_d_source[LB-1:0];
  assign d_tag  = mem_d_source[SRC_WIDTH-1:LB];
  assign d_fire = mem_d_valid && mem_d_ready;
  assign d_ok   = d_fire && (state == ISSUE || state == WAIT) &&
                  (d_tag == tag_q) && rsp_pend[d_lane];
  assign a_fire = mem_a_valid && mem_a_ready;

  assign issue_nx = a_fire ? (issue_pend & ~(NUM_LANES'(1) << a_lane)) : issue_pend;
  assign rsp_nx   = d_ok   ? (rsp_pend   & ~(NUM_LANES'(1) << d_lane)) : rsp_pend;

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      issue_pend <= '0;
      rsp_pend   <= '0;
      rd_mask    <= '0;
      rw_q       <= '0;
      tag_q      <= '0;
      err_q      <= 1'b0;
      for (int i = 0; i < NUM_LANES; i++) begin
        byteen_q[i] <= '0;
        addr_q[i]   <= '0;
        wdata_q[i]  <= '0;
        data_buf[i] <= '0;
      end
    end else begin
      if (d_fire && !d_ok) err_q <= 1'b1;
      case (state)
        IDLE: begin
          // An empty mask is consumed here without leaving IDLE.
          if (req_valid && req_mask != '0) begin
            tag_q      <= req_tag;
            rw_q       <= req_rw;
            issue_pend <= req_mask;
            rsp_pend   <= req_mask;
            rd_mask    <= req_mask & ~req_rw;
            for (int i = 0; i < NUM_LANES; i++) begin
              byteen_q[i] <= req_byteen[4*i +: 4];
              addr_q[i]   <= req_addr[30*i +: 30];
              wdata_q[i]  <= req_data[32*i +: 32];
              data_buf[i] <= '0;
            end
            state <= ISSUE;
          end
        end
        ISSUE, WAIT: begin
          issue_pend <= issue_nx;
          rsp_pend   <= rsp_nx;
          if (d_ok && mem_d_opcode != 3'd0) data_buf[d_lane] <= mem_d_data;
          if (issue_nx == '0 && rsp_nx == '0)
            state <= (rd_mask != '0) ? RESP : IDLE;
          else if (issue_nx == '0)
            state <= WAIT;
        end
        RESP: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_lane_serializer.sv
// tb/tb_dmem_lane_serializer.sv - randomized bench for dmem_lane_serializer against a lane-level
// transaction model with a scripted/random TL memory responder.
module tb_dmem_lane_serializer;
  localparam int N = 4;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [3:0]   req_mask = '0;
  logic [3:0]   req_rw = '0;
  logic [15:0]  req_byteen = '0;
  logic [119:0] req_addr = '0;
  logic [127:0] req_data = '0;
  logic [7:0]   req_tag = '0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [3:0]   rsp_tmask;
  logic [127:0] rsp_data;
  logic [7:0]   rsp_tag;
  logic         mem_a_valid;
  logic         mem_a_ready = 1'b0;
  logic [2:0]   mem_a_opcode;
  logic [3:0]   mem_a_size;
  logic [9:0]   mem_a_source;
  logic [31:0]  mem_a_address;
  logic [3:0]   mem_a_mask;
  logic [31:0]  mem_a_data;
  logic         mem_d_valid = 1'b0;
  logic         mem_d_ready;
  logic [2:0]   mem_d_opcode = '0;
  logic [9:0]   mem_d_source = '0;
  logic [31:0]  mem_d_data = '0;
  logic         busy;
  logic         err;

  dmem_lane_serializer #(.NUM_LANES(4), .TAG_WIDTH(8), .SRC_WIDTH(10)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_mask(req_mask), .req_rw(req_rw),
    .req_byteen(req_byteen), .req_addr(req_addr), .req_data(req_data), .req_tag(req_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_tmask(rsp_tmask), .rsp_data(rsp_data),
    .rsp_tag(rsp_tag),
    .mem_a_valid(mem_a_valid), .mem_a_ready(mem_a_ready), .mem_a_opcode(mem_a_opcode),
    .mem_a_size(mem_a_size), .mem_a_source(mem_a_source), .mem_a_address(mem_a_address),
    .mem_a_mask(mem_a_mask), .mem_a_data(mem_a_data),
    .mem_d_valid(mem_d_valid), .mem_d_ready(mem_d_ready), .mem_d_opcode(mem_d_opcode),
    .mem_d_source(mem_d_source), .mem_d_data(mem_d_data),
    .busy(busy), .err(err)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Transaction description and model state
  logic [3:0]  t_mask, t_rw;
  logic [7:0]  t_tag;
  logic [3:0]  t_be[N];
  logic [29:0] t_addr[N];
  logic [31:0] t_wdata[N];
  logic [31:0] t_rdata[N];
  int          t_dmode, t_astall, t_rstall, t_hold;
  int          inj_cyc[$];
  logic [9:0]  inj_src[$];
  logic [31:0] inj_dat[$];
  logic [2:0]  inj_op[$];
  logic        err_exp = 1'b0;
  int          rsp_cyc;

  function automatic logic [84:0] a_beat(input int l);
    logic [2:0] op;
    op = !t_rw[l] ? 3'd4 : ((t_be[l] == 4'hF) ? 3'd0 : 3'd1);
    return {op, 4'd2, t_tag, 2'(l), t_addr[l], 2'b00, t_be[l], t_wdata[l]};
  endfunction

  task automatic base_txn(input logic [3:0] m, input logic [3:0] rw, input logic [7:0] tag);
    t_mask = m; t_rw = rw; t_tag = tag;
    for (int i = 0; i < N; i++) begin
      t_be[i] = 4'hF;
      t_addr[i] = 30'h100 + 30'(i);
      t_wdata[i] = 32'h5000_0000 + 32'(i);
      t_rdata[i] = 32'hA0 + 32'(i);
    end
    t_dmode = 0; t_astall = 0; t_rstall = 0; t_hold = 0;
  endtask

  task automatic rand_txn();
    t_mask = 4'($urandom_range(15, 1));
    t_rw = 4'($urandom);
    t_tag = 8'($urandom);
    for (int i = 0; i < N; i++) begin
      t_be[i] = ($urandom_range(1, 0) == 1) ? 4'hF : 4'($urandom);
      t_addr[i] = 30'($urandom);
      t_wdata[i] = $urandom;
      t_rdata[i] = $urandom;
    end
    t_dmode = int'($urandom_range(1, 0));
    t_astall = int'($urandom_range(50, 0));
    t_rstall = int'($urandom_range(50, 0));
    t_hold = 0;
  endtask

  task automatic add_inj(input int c, input logic [9:0] s, input logic [31:0] d, input logic [2:0] op);
    inj_cyc.push_back(c); inj_src.push_back(s); inj_dat.push_back(d); inj_op.push_back(op);
  endtask

  // Runs one request from an IDLE negedge until the block is idle again.
  task automatic run_txn();
    int pend_a[$];
    int out_q[$];
    logic [3:0]   done, rd;
    logic [31:0]  mbuf[N];
    logic [127:0] ed;
    logic         rsp_done, in_flight, want_rsp, dv, ar, rr, finished;
    logic [9:0]   ds;
    logic [31:0]  dd;
    logic [2:0]   dop;
    int           dl, k;
    done = '0; rsp_done = 1'b0; finished = 1'b0;
    ds = '0; dd = '0; dop = '0;
    rd = t_mask & ~t_rw;
    for (int i = 0; i < N; i++) begin
      mbuf[i] = '0;
      if (t_mask[i]) pend_a.push_back(i);
    end
    check("req_ready_idle", 192'(req_ready), 192'(1'b1));
    req_valid = 1'b1; req_mask = t_mask; req_rw = t_rw; req_tag = t_tag;
    for (int i = 0; i < N; i++) begin
      req_byteen[4*i +: 4] = t_be[i];
      req_addr[30*i +: 30] = t_addr[i];
      req_data[32*i +: 32] = t_wdata[i];
    end
    rsp_cyc = -1;
    @(negedge clock);
    req_valid = 1'b0;
    for (int cyc = 1; cyc <= 300 && !finished; cyc++) begin
      in_flight = (pend_a.size() != 0) || (done != t_mask);
      want_rsp = !in_flight && rd != 0 && !rsp_done;
      check("err", 192'(err), 192'(err_exp));
      check("busy", 192'(busy), 192'(in_flight || want_rsp));
      check("a_valid", 192'(mem_a_valid), 192'(pend_a.size() != 0));
      if (pend_a.size() != 0)
        check("a_beat", 192'({mem_a_opcode, mem_a_size, mem_a_source, mem_a_address, mem_a_mask, mem_a_data}),
              192'(a_beat(pend_a[0])));
      check("rsp_valid", 192'(rsp_valid), 192'(want_rsp));
      if (want_rsp) begin
        for (int i = 0; i < N; i++) ed[32*i +: 32] = rd[i] ? mbuf[i] : 32'h0;
        check("rsp_fields", 192'({rsp_tmask, rsp_tag, rsp_data}), 192'({rd, t_tag, ed}));
        if (rsp_cyc < 0) rsp_cyc = cyc;
      end
      if (!in_flight && (rd == 0 || rsp_done)) begin
        check("req_ready_back", 192'(req_ready), 192'(1'b1));
        finished = 1'b1;
      end else begin
        dv = 1'b0;
        if (inj_cyc.size() != 0 && inj_cyc[0] == cyc) begin
          dv = 1'b1; ds = inj_src[0]; dd = inj_dat[0]; dop = inj_op[0];
          void'(inj_cyc.pop_front()); void'(inj_src.pop_front());
          void'(inj_dat.pop_front()); void'(inj_op.pop_front());
        end else if (out_q.size() != 0 &&
                     (t_dmode == 0 || (t_dmode == 1 && $urandom_range(1, 0) == 1))) begin
          k = (t_dmode == 0) ? 0 : int'($urandom_range(out_q.size() - 1, 0));
          dl = out_q[k];
          out_q.delete(k);
          dv = 1'b1; ds = {t_tag, 2'(dl)}; dd = t_rdata[dl]; dop = t_rw[dl] ? 3'd0 : 3'd1;
        end
        mem_d_valid = dv; mem_d_source = ds; mem_d_data = dd; mem_d_opcode = dop;
        if (dv) begin
          dl = int'(ds[1:0]);
          if (in_flight && ds[9:2] == t_tag && t_mask[dl] && !done[dl]) begin
            done[dl] = 1'b1;
            if (dop != 3'd0) mbuf[dl] = dd;
          end else begin
            err_exp = 1'b1;
          end
        end
        ar = (cyc > t_hold) && ($urandom_range(99, 0) >= 32'(t_astall));
        mem_a_ready = ar;
        if (ar && pend_a.size() != 0) out_q.push_back(pend_a.pop_front());
        rr = ($urandom_range(99, 0) >= 32'(t_rstall));
        rsp_ready = rr;
        if (rr && want_rsp) rsp_done = 1'b1;
        @(negedge clock);
      end
    end
    if (!finished) check("txn_timeout", 192'(1'b0), 192'(1'b1));
    mem_d_valid = 1'b0; mem_a_ready = 1'b0; rsp_ready = 1'b0;
    inj_cyc.delete(); inj_src.delete(); inj_dat.delete(); inj_op.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clock);
    check("rst_req_ready", 192'(req_ready), 192'(1'b0));
    check("rst_d_ready", 192'(mem_d_ready), 192'(1'b0));
    check("rst_outputs", 192'({busy, rsp_valid, mem_a_valid, err}), 192'(4'b0000));
    reset = 1'b0;
    @(negedge clock);
    check("post_rst_ready", 192'({req_ready, mem_d_ready}), 192'(2'b11));

    // 4-lane load, one-cycle memory
    base_txn(4'hF, 4'h0, 8'h3C);
    run_txn();
    check("load4_rsp_cycle", 192'(rsp_cyc), 192'(6));

    // Mixed load / partial store
    base_txn(4'b1010, 4'b1000, 8'h51);
    t_be[3] = 4'h3;
    run_txn();

    // Store-only with A backpressure
    base_txn(4'b0011, 4'b0011, 8'h22);
    t_hold = 3;
    run_txn();
    check("store_no_rsp", 192'(rsp_cyc), 192'(-1));

    // Out-of-order D: lanes 3,1,0,2; lane 3 alongside the lane-2 A fire
    base_txn(4'hF, 4'h0, 8'h77);
    t_dmode = 2;
    add_inj(3, {8'h77, 2'd3}, 32'hA3, 3'd1);
    add_inj(5, {8'h77, 2'd1}, 32'hA1, 3'd1);
    add_inj(6, {8'h77, 2'd0}, 32'hA0, 3'd1);
    add_inj(7, {8'h77, 2'd2}, 32'hA2, 3'd1);
    run_txn();

    for (int n = 0; n < 30; n++) begin
      rand_txn();
      run_txn();
    end

    // Stray D beats: wrong tag, then duplicate lane 0
    base_txn(4'hF, 4'h0, 8'h90);
    add_inj(3, {8'h91, 2'd1}, 32'hDEAD_0001, 3'd1);
    add_inj(4, {8'h90, 2'd0}, 32'hDEAD_0000, 3'd1);
    run_txn();
    check("stray_err", 192'(err), 192'(1'b1));

    for (int n = 0; n < 10; n++) begin
      rand_txn();
      run_txn();
    end

    // Reset while waiting on D, then a late beat
    base_txn(4'hF, 4'h0, 8'h44);
    req_valid = 1'b1; req_mask = 4'hF; req_rw = 4'h0; req_tag = 8'h44;
    @(negedge clock);
    req_valid = 1'b0;
    mem_a_ready = 1'b1;
    repeat (5) @(negedge clock);
    check("wait_state", 192'({busy, mem_a_valid, rsp_valid}), 192'(3'b100));
    mem_a_ready = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    check("midrst_ready", 192'({req_ready, mem_d_ready}), 192'(2'b00));
    check("midrst_state", 192'({busy, rsp_valid, err}), 192'(3'b000));
    reset = 1'b0;
    err_exp = 1'b0;
    mem_d_valid = 1'b1; mem_d_source = {8'h44, 2'd0}; mem_d_opcode = 3'd1; mem_d_data = 32'h1234;
    @(negedge clock);
    mem_d_valid = 1'b0;
    err_exp = 1'b1;
    check("late_d_err", 192'(err), 192'(1'b1));
    check("late_d_idle", 192'({busy, rsp_valid, req_ready, mem_d_ready}), 192'(4'b0011));

    // Empty mask is consumed in IDLE without A traffic
    req_valid = 1'b1; req_mask = 4'h0;
    @(negedge clock);
    req_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check("empty_mask", 192'({busy, mem_a_valid, rsp_valid, req_ready}), 192'(4'b0001));
      @(negedge clock);
    end

    for (int n = 0; n < 5; n++) begin
      rand_txn();
      run_txn();
    end
    check("err_sticky", 192'(err), 192'(1'b1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
